aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  AES-128 key schedule engine feeding the AddRoundKey stage of the encryption datapath.
//  Accepts a 128-bit cipher key and streams round keys RK0..RK10 one per handshake.
//  Derives each next key iteratively in 1 cycle from the current one (RotWord/SubWord/Rcon).
//  Supports downstream backpressure: a round key is held until the consumer takes it.
// PARAMETERS
//  NR        10   number of rounds (AES-128 only; other values unsupported)
//  KEY_W     128  key / round-key width in bits
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    load key_in and begin schedule; accepted only when busy==0
//  key_in     in   128  cipher key, byte 0 = bits [127:120]
//  busy       out  1    schedule in progress (from start accept to final handshake)
//  rk_valid   out  1    rk_data holds a valid round key
//  rk_ready   in   1    consumer accepts rk_data this cycle
//  rk_data    out  128  current round key
//  rk_round   out  4    index of rk_data, 0..10
//  rk_last    out  1    high with rk_valid when rk_round==NR
//  done       out  1    1-cycle pulse after RK10 handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, rk_valid, rk_last, done = 0; rk_data = 0; rk_round = 0.
//  FSM: IDLE -> (start) -> EMIT -> (handshake on RK10) -> IDLE.
//   IDLE: start=1 registers key_in as rk_data, rk_round=0, rk_valid=1, busy=1 next cycle.
//   EMIT: handshake = rk_valid & rk_ready.
//    handshake & rk_round<NR: rk_data <= next_key(rk_data, RCON[rk_round+1]); rk_round++.
//    handshake & rk_round==NR: rk_valid<=0, busy<=0, done<=1 (1 cycle), -> IDLE.
//    no handshake: rk_data, rk_round, rk_valid held stable (AXI-style; no retraction).
//  Latency: start to RK0 valid = 1 cycle; each subsequent key valid the cycle after handshake.
//   Full-throughput with rk_ready=1: 11 consecutive valid cycles, done on cycle 12.
//  next_key: temp = SubWord(RotWord(w3)) ^ {RCON,24'h0}; w0'=w0^temp; w1'=w1^w0';
//   w2'=w2^w1'; w3'=w3^w2'. w0 = bits [127:96]. All XOR, no carries.
//  start while busy=1: ignored, no effect on schedule. start in same cycle as done: accepted.
//  rk_ready while rk_valid=0: ignored. rk_round never exceeds NR; no wrap.
//  Reset mid-schedule: immediate return to reset values; partial schedule discarded.
// CONFIGURATION
//  AES_RKEY_STORE_EN defined: adds 11x128 key store written on each handshake, plus ports
//   rd_idx in 4 and rd_key out 128 (combinational read; rd_idx>10 returns 0).
//   Stored contents persist until next start; reset clears store to 0.
//   Gives decryption reverse-order access to round keys.
//  Not defined: no store, no rd_idx/rd_key ports; streaming only.
// STRUCTURE
//  Package aes_pkg: KEY_W, NR, word_t (32-bit), key_t (128-bit), RCON[1:10] table
//   (01,02,04,08,10,20,40,80,1b,36), state enum {IDLE, EMIT}, sub_word/rot_word functions.
//  Sub-module aes_sbox: combinational 8->8 S-box, 4 instances for SubWord.
//  Shared with SubBytes stage.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK0=key,
//    RK1=a0fafe1788542cb123a339392a6c7605, RK10=d014f9a8c9ee2589e13f0cc8b6630ca6, done cycle 12.
//  2 Same key, rk_ready toggled randomly -> identical RK sequence, rk_data stable while stalled.
//  3 Key all-zero -> RK1=62636363626363636263636362636363; rk_last only with rk_round=10.
//  4 start pulsed while busy at round 4 with key FF..FF -> ignored; schedule completes for first key.
//  5 rst_n=0 at round 6 -> busy, rk_valid=0 at once; new start afterwards yields correct RK0..RK10.
//  6 AES_RKEY_STORE_EN: after test 1, rd_idx=10 -> d014f9a8...0ca6; rd_idx=12 -> 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, types, round constants and S-box lookup.
// Used by the key schedule and the SubBytes stage.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  typedef logic [31:0]      word_t;
  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte 0x00 sits in the top byte, 0xff in the bottom byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8 bits in, 8 bits out.
// Shared with the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox(a);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams RK0..RK10 over a valid/ready handshake.
// Define AES_RKEY_STORE_EN to keep all round keys for random read-back.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
`ifdef AES_RKEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  state_t state, state_n;

  logic       hs;
  logic       fin;
  logic [3:0] rnext;
  logic [7:0] rc;
  word_t      w0, w1, w2, w3;
  word_t      rot, sub, temp;
  word_t      n0, n1, n2, n3;

  assign hs    = rk_valid & rk_ready;
  assign fin   = hs && (rk_round == 4'(NR));
  assign rnext = rk_round + 4'd1;

  assign rk_last = rk_valid && (rk_round == 4'(NR));

  always_comb begin
    rc = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (rnext == 4'(i)) rc = RCON[i];
    end
  end

  assign {w0, w1, w2, w3} = rk_data;
  assign rot = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign temp = sub ^ {rc, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = EMIT;
      EMIT: if (fin)   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rk_data  <= key_in;
            rk_round <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        EMIT: begin
          if (fin) begin
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (hs) begin
            rk_data  <= {n0, n1, n2, n3};
            rk_round <= rnext;
          end
        end
      endcase
    end
  end

`ifdef AES_RKEY_STORE_EN
  key_t store [0:NR];

  // A new schedule wipes the previous key set before refilling it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (state == IDLE && start) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (hs) begin
      store[rk_round] <= rk_data;
    end
  end

  assign rd_key = (rd_idx <= 4'(NR)) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for the AES-128 key schedule engine.
// Covers streaming, backpressure, ignored start, reset and key store.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         done;
`ifdef AES_RKEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .done     (done)
`ifdef AES_RKEY_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [127:0] key);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_fips(input string tag);
    rk_ready = 1'b1;
    kick(fips[0]);
    for (int i = 0; i <= 10; i++) begin
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      chk({tag, "_data"}, rk_data, fips[i]);
      chk({tag, "_round"}, 128'(rk_round), 128'(i));
      chk({tag, "_last"}, 128'(rk_last), 128'(i == 10));
      @(negedge clk);
    end
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_busy_end"}, 128'(busy), 128'(0));
    chk({tag, "_valid_end"}, 128'(rk_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] prev;
    logic         stalled;
    logic         r;
    int           idx;
    int           cyc;

    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
`ifdef AES_RKEY_STORE_EN
    rd_idx   = '0;
`endif
    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_last", 128'(rk_last), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 key at full throughput; done lands on cycle 12
    run_fips("t1");
`ifdef AES_RKEY_STORE_EN
    rd_idx = 4'd10;
    #1 chk("t6_rd10", rd_key, fips[10]);
    rd_idx = 4'd0;
    #1 chk("t6_rd0", rd_key, fips[0]);
    rd_idx = 4'd12;
    #1 chk("t6_rd12", rd_key, 128'(0));
    rd_idx = 4'd5;
    #1 chk("t6_rd5", rd_key, fips[5]);
`endif
    // start in the done cycle must be accepted: all-zero key
    key_in = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("t3_done_clr", 128'(done), 128'(0));
    for (int i = 0; i <= 10; i++) begin
      chk("t3_valid", 128'(rk_valid), 128'(1));
      chk("t3_last", 128'(rk_last), 128'(i == 10));
      chk("t3_round", 128'(rk_round), 128'(i));
      if (i == 0)
        chk("t3_rk0", rk_data, 128'(0));
      if (i == 1)
        chk("t3_rk1", rk_data,
            128'h62636363626363636263636362636363);
      if (i == 2)
        chk("t3_rk2", rk_data,
            128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
      if (i == 10)
        chk("t3_rk10", rk_data,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      @(negedge clk);
    end
    chk("t3_done", 128'(done), 128'(1));

    // random backpressure: same sequence, data frozen while stalled
    rk_ready = 1'b0;
    kick(fips[0]);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (idx < 11 && cyc < 400) begin
      if (stalled) begin
        chk("t2_stall_data", rk_data, prev);
        chk("t2_stall_valid", 128'(rk_valid), 128'(1));
      end
      r = 1'($urandom_range(0, 1));
      rk_ready = r;
      if (rk_valid && r) begin
        chk("t2_data", rk_data, fips[idx]);
        chk("t2_round", 128'(rk_round), 128'(idx));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = rk_valid;
        prev = rk_data;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t2_count", 128'(idx), 128'(11));
    chk("t2_done", 128'(done), 128'(1));

    // start with a different key mid-schedule is ignored
    rk_ready = 1'b1;
    kick(fips[0]);
    for (int i = 0; i <= 10; i++) begin
      start  = (i == 4);
      key_in = {128{1'b1}};
      chk("t4_data", rk_data, fips[i]);
      chk("t4_round", 128'(rk_round), 128'(i));
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_done", 128'(done), 128'(1));
    @(negedge clk);
    chk("t4_idle_valid", 128'(rk_valid), 128'(0));
    chk("t4_idle_busy", 128'(busy), 128'(0));

    // asynchronous reset at round 6 discards the schedule
    kick(fips[0]);
    for (int i = 0; i <= 6; i++) begin
      chk("t5_data", rk_data, fips[i]);
      if (i < 6) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_valid", 128'(rk_valid), 128'(0));
    chk("t5_round", 128'(rk_round), 128'(0));
    chk("t5_data0", rk_data, 128'(0));
`ifdef AES_RKEY_STORE_EN
    rd_idx = 4'd3;
    #1 chk("t5_store_clr", rd_key, 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_fips("t5r");
    @(negedge clk);
    chk("t5_done_pulse", 128'(done), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
